y_buf_argmax_rd: RTL and testbench

- Read-side consumer of the MLP output buffer: after the processing unit has written its FP32 class scores, this block reads them back.
- Reads CLASS_NUM scores per image from a 1-cycle-latency BRAM read port. Word addresses step by ADDR_STEP (0, 4, 8, …).
- Computes the argmax per image and presents {image index, label, max score} on a valid/ready result interface.
- Sits between the y buffer's second port and the host/LED readout path; started by the global controller's done pulse.

---
 rtl/y_buf_argmax_rd.sv | 131 +++++++++++++
 tb/tb_y_buf_argmax_rd.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/y_buf_argmax_rd.sv
// Argmax reader for the MLP y buffer: streams CLASS_NUM FP32 scores per image and emits {img, label, score}.
// Optional macro Y_RD_TIE_LAST_EN: ties resolve to the highest class index instead of the lowest.
module y_buf_argmax_rd #(
    parameter int IMG_NUM          = 1,
    parameter int CLASS_NUM        = 10,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_DEPTH      = 10*IMG_NUM*4,
    parameter int ADDR_STEP        = 4,
    localparam int AW = $clog2(Y_BUF_DEPTH),
    localparam int IW = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1,
    localparam int LW = $clog2(CLASS_NUM)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        y_rd_en,
    output logic [AW-1:0]               y_rd_addr,
    input  logic [Y_BUF_DATA_WIDTH-1:0] y_rd_data,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [IW-1:0]               res_img,
    output logic [LW-1:0]               res_label,
    output logic [Y_BUF_DATA_WIDTH-1:0] res_score
);
    localparam int W = Y_BUF_DATA_WIDTH;
    localparam logic [W-1:0] SIGN = {1'b1, {(W-1){1'b0}}};

    if (IMG_NUM*CLASS_NUM*ADDR_STEP > Y_BUF_DEPTH) begin : g_depth_chk
        $error("y_buf_argmax_rd: IMG_NUM*CLASS_NUM*ADDR_STEP exceeds Y_BUF_DEPTH");
    end

    typedef enum logic [2:0] {IDLE, READ, LAST, OUT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] img_q, img_d;
    logic [LW-1:0] cls_q, cls_d;
    logic          pend_q, pend_d;
    logic [LW-1:0] cmp_idx_q, cmp_idx_d;
    logic [W-1:0]  best_key_q, best_key_d;
    logic [LW-1:0] best_idx_q, best_idx_d;
    logic [W-1:0]  cur_key;
    logic          win;

    // Monotonic unsigned key so an integer compare orders IEEE-754 values.
    assign cur_key = y_rd_data[W-1] ? ~y_rd_data : (y_rd_data ^ SIGN);

`ifdef Y_RD_TIE_LAST_EN
    assign win = (cur_key >= best_key_q);
`else
    assign win = (cur_key > best_key_q);
`endif

    always_comb begin
        state_d    = state_q;
        img_d      = img_q;
        cls_d      = cls_q;
        pend_d     = 1'b0;
        cmp_idx_d  = cmp_idx_q;
        best_key_d = best_key_q;
        best_idx_d = best_idx_q;

        // Data returned for the previous cycle's read is folded in here.
        if (pend_q && ((cmp_idx_q == '0) || win)) begin
            best_key_d = cur_key;
            best_idx_d = cmp_idx_q;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = READ;
                    img_d   = '0;
                    cls_d   = '0;
                end
            end
            READ: begin
                pend_d    = 1'b1;
                cmp_idx_d = cls_q;
                if (cls_q == LW'(CLASS_NUM-1)) state_d = LAST;
                else                           cls_d   = cls_q + 1'b1;
            end
            LAST: state_d = OUT;
            OUT: begin
                if (res_ready) begin
                    if (img_q == IW'(IMG_NUM-1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        img_d   = img_q + 1'b1;
                        cls_d   = '0;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            img_q      <= '0;
            cls_q      <= '0;
            pend_q     <= 1'b0;
            cmp_idx_q  <= '0;
            best_key_q <= '0;
            best_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            img_q      <= img_d;
            cls_q      <= cls_d;
            pend_q     <= pend_d;
            cmp_idx_q  <= cmp_idx_d;
            best_key_q <= best_key_d;
            best_idx_q <= best_idx_d;
        end
    end

    assign busy_o    = (state_q == READ) || (state_q == LAST) || (state_q == OUT);
    assign done_o    = (state_q == DONE);
    assign y_rd_en   = (state_q == READ);
    assign y_rd_addr = y_rd_en ? AW'((32'(img_q) * CLASS_NUM + 32'(cls_q)) * ADDR_STEP) : '0;
    assign res_valid = (state_q == OUT);
    assign res_img   = res_valid ? img_q : '0;
    assign res_label = res_valid ? best_idx_q : '0;
    // Invert the order key back to the raw score bits.
    assign res_score = !res_valid ? '0 :
                       best_key_q[W-1] ? (best_key_q ^ SIGN) : ~best_key_q;
endmodule

// File: tb/tb_y_buf_argmax_rd.sv
// Scoreboard bench for y_buf_argmax_rd with a 3-image configuration and a 1-cycle BRAM model.
module tb_y_buf_argmax_rd;
    localparam int IMG = 3;
    localparam int CLS = 10;
    localparam int DEPTH = CLS*IMG*4;
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(IMG);
    localparam int LW = $clog2(CLS);

    typedef struct { int img; int lbl; logic [31:0] scr; } res_t;

    logic          clk = 1'b0;
    logic          rst, start_i, res_ready;
    logic          busy_o, done_o, y_rd_en, res_valid;
    logic [AW-1:0] y_rd_addr;
    logic [31:0]   y_rd_data;
    logic [IW-1:0] res_img;
    logic [LW-1:0] res_label;
    logic [31:0]   res_score;

    logic [31:0] mem [0:IMG*CLS-1];
    int cyc = 0;
    int checks = 0, failures = 0;

    res_t exp_q[$], obs_q[$];
    int   addr_q[$], rd_rel_q[$], hs_rel_q[$];
    int   first_valid_rel, done_cnt, done_rel, stall_err, rd_stall, timed_out;

    y_buf_argmax_rd #(.IMG_NUM(IMG), .CLASS_NUM(CLS), .Y_BUF_DATA_WIDTH(32),
                      .Y_BUF_DEPTH(DEPTH), .ADDR_STEP(4)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .y_rd_en(y_rd_en), .y_rd_addr(y_rd_addr), .y_rd_data(y_rd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_img(res_img),
        .res_label(res_label), .res_score(res_score));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (y_rd_en) y_rd_data <= mem[int'(y_rd_addr) / 4];

    function automatic logic [31:0] key_of(input logic [31:0] b);
        return b[31] ? ~b : (b ^ 32'h8000_0000);
    endfunction

    function automatic void push_expected();
        int bl;
        logic [31:0] bk, k;
        exp_q.delete();
        for (int i = 0; i < IMG; i++) begin
            bl = 0;
            bk = key_of(mem[i*CLS]);
            for (int c = 1; c < CLS; c++) begin
                k = key_of(mem[i*CLS+c]);
`ifdef Y_RD_TIE_LAST_EN
                if (k >= bk) begin bk = k; bl = c; end
`else
                if (k > bk) begin bk = k; bl = c; end
`endif
            end
            exp_q.push_back('{i, bl, mem[i*CLS+bl]});
        end
    endfunction

    task automatic do_run(input int stall, input bit poke);
        int s, rel, stall_cnt;
        bit fin, prev_stalled;
        logic [IW-1:0] p_img;
        logic [LW-1:0] p_lbl;
        logic [31:0]   p_scr;
        addr_q.delete(); rd_rel_q.delete(); obs_q.delete(); hs_rel_q.delete();
        first_valid_rel = -1; done_cnt = 0; done_rel = -1;
        stall_err = 0; rd_stall = 0; timed_out = 0;
        push_expected();
        res_ready = (stall == 0);
        @(negedge clk); start_i = 1'b1; s = cyc;
        @(negedge clk); start_i = 1'b0;
        fin = 0; stall_cnt = 0; prev_stalled = 0;
        p_img = '0; p_lbl = '0; p_scr = '0;
        for (int n = 0; n < 1000 && !fin; n++) begin
            if (n > 0) @(negedge clk);
            rel = cyc - s;
            if (y_rd_en) begin addr_q.push_back(int'(y_rd_addr)); rd_rel_q.push_back(rel); end
            if (y_rd_en && res_valid) rd_stall++;
            if (res_valid && first_valid_rel < 0) first_valid_rel = rel;
            if (prev_stalled && (!res_valid || res_img !== p_img || res_label !== p_lbl ||
                                 res_score !== p_scr)) stall_err++;
            if (done_o) begin done_cnt++; done_rel = rel; fin = 1; end
            if (res_valid) begin
                if (stall_cnt < stall) begin res_ready = 1'b0; stall_cnt++; end
                else res_ready = 1'b1;
                if (res_ready) begin
                    obs_q.push_back('{int'(res_img), int'(res_label), res_score});
                    hs_rel_q.push_back(rel);
                    stall_cnt = 0;
                end
            end else begin
                res_ready = (stall == 0);
            end
            prev_stalled = res_valid && !res_ready;
            p_img = res_img; p_lbl = res_label; p_scr = res_score;
            start_i = poke && busy_o && (rel % 7 == 3);
        end
        start_i = 1'b0;
        if (!fin) timed_out = 1;
        repeat (3) begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (busy_o) stall_err++;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy_o, done_o, y_rd_en, res_valid} !== 4'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 0000", {busy_o, done_o, y_rd_en, res_valid}); end
        checks++; if ({y_rd_addr, res_img, res_label} !== '0) begin
            failures++; $display("FAIL reset_addr_lbl: got %h want 0", {y_rd_addr, res_img, res_label}); end
        checks++; if (res_score !== 32'h0) begin
            failures++; $display("FAIL reset_score: got %h want 0", res_score); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ascending();
        logic [31:0] asc [0:9];
        res_t e, o;
        asc = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};
        for (int c = 0; c < CLS; c++) begin
            mem[c]       = asc[c];
            mem[CLS+c]   = asc[9-c];
            mem[2*CLS+c] = $urandom;
        end
        do_run(0, 0);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL asc_timeout: got %0d want 0", timed_out); end
        checks++; if (obs_q.size() !== IMG) begin
            failures++; $display("FAIL asc_count: got %0d want %0d", obs_q.size(), IMG); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0].lbl !== 9 || obs_q[0].scr !== 32'h41100000 || obs_q[0].img !== 0) begin
                failures++; $display("FAIL asc_img0: got img %0d lbl %0d scr %h want 0 9 41100000",
                                     obs_q[0].img, obs_q[0].lbl, obs_q[0].scr); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.img !== e.img || o.lbl !== e.lbl || o.scr !== e.scr) begin
                failures++; $display("FAIL asc_result: got %0d/%0d/%h want %0d/%0d/%h",
                                     o.img, o.lbl, o.scr, e.img, e.lbl, e.scr); end
        end
        checks++; if (addr_q.size() !== IMG*CLS) begin
            failures++; $display("FAIL asc_nreads: got %0d want %0d", addr_q.size(), IMG*CLS); end
        for (int k = 0; k < addr_q.size(); k++) begin
            checks++; if (addr_q[k] !== 4*k) begin
                failures++; $display("FAIL asc_addr[%0d]: got %0d want %0d", k, addr_q[k], 4*k); end
        end
        if (rd_rel_q.size() >= 10) begin
            checks++; if (rd_rel_q[0] !== 1 || rd_rel_q[9] !== 10) begin
                failures++; $display("FAIL asc_read_cycles: got %0d..%0d want 1..10", rd_rel_q[0], rd_rel_q[9]); end
        end
        checks++; if (first_valid_rel !== 12) begin
            failures++; $display("FAIL asc_valid_cycle: got %0d want 12", first_valid_rel); end
        if (hs_rel_q.size() > 0) begin
            checks++; if (done_rel !== hs_rel_q[hs_rel_q.size()-1] + 1) begin
                failures++; $display("FAIL asc_done_cycle: got %0d want %0d", done_rel,
                                     hs_rel_q[hs_rel_q.size()-1] + 1); end
        end
        checks++; if (done_cnt !== 1 || stall_err !== 0) begin
            failures++; $display("FAIL asc_done_pulse: got done %0d busy_err %0d want 1 0", done_cnt, stall_err); end
    endtask

    task automatic test_stall_signs_ties();
        logic [31:0] neg [0:8];
        res_t e, o;
        int tie_lbl;
        neg = '{32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hC0A00000, 32'hC0C00000,
                32'hC0E00000, 32'hC1000000, 32'hC1100000, 32'hC1200000};
        for (int c = 0, j = 0; c < CLS; c++) begin
            if (c == 3) mem[c] = 32'hBF800000;
            else begin mem[c] = neg[j]; j++; end
            mem[CLS+c]   = 32'hBF800000;
            mem[2*CLS+c] = 32'h00000000;
        end
        mem[CLS+0] = 32'h80000000;
        mem[CLS+2] = 32'h00000000;
        mem[2*CLS+4] = 32'h40000000;
        mem[2*CLS+7] = 32'h40000000;
`ifdef Y_RD_TIE_LAST_EN
        tie_lbl = 7;
`else
        tie_lbl = 4;
`endif
        do_run(5, 1);
        checks++; if (timed_out !== 0) begin failures++; $display("FAIL stall_timeout: got %0d want 0", timed_out); end
        checks++; if (obs_q.size() !== IMG) begin
            failures++; $display("FAIL stall_count: got %0d want %0d", obs_q.size(), IMG); end
        if (obs_q.size() == IMG) begin
            checks++; if (obs_q[0].lbl !== 3 || obs_q[1].lbl !== 2 || obs_q[2].lbl !== tie_lbl) begin
                failures++; $display("FAIL stall_labels: got %0d %0d %0d want 3 2 %0d",
                                     obs_q[0].lbl, obs_q[1].lbl, obs_q[2].lbl, tie_lbl); end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.img !== e.img || o.lbl !== e.lbl || o.scr !== e.scr) begin
                failures++; $display("FAIL stall_result: got %0d/%0d/%h want %0d/%0d/%h",
                                     o.img, o.lbl, o.scr, e.img, e.lbl, e.scr); end
        end
        checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_stable: got %0d want 0", stall_err); end
        checks++; if (rd_stall !== 0) begin failures++; $display("FAIL stall_reads: got %0d want 0", rd_stall); end
        checks++; if (addr_q.size() !== IMG*CLS) begin
            failures++; $display("FAIL stall_nreads: got %0d want %0d", addr_q.size(), IMG*CLS); end
        if (addr_q.size() >= 20) begin
            for (int k = 10; k < 20; k++) begin
                checks++; if (addr_q[k] !== 4*k) begin
                    failures++; $display("FAIL stall_img1_addr[%0d]: got %0d want %0d", k, addr_q[k], 4*k); end
            end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        int seen;
        res_t e, o;
        for (int k = 0; k < IMG*CLS; k++) mem[k] = $urandom;
        res_ready = 1'b1;
        @(negedge clk); start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (y_rd_en !== 1'b1) begin failures++; $display("FAIL abort_in_read: got %b want 1", y_rd_en); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({busy_o, done_o, y_rd_en, res_valid, y_rd_addr, res_img, res_label, res_score} !== '0) begin
            failures++; $display("FAIL abort_outputs: got %h want 0",
                {busy_o, done_o, y_rd_en, res_valid, y_rd_addr, res_img, res_label, res_score}); end
        rst = 1'b0;
        seen = 0;
        repeat (30) begin @(negedge clk); if (res_valid || done_o || busy_o) seen++; end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_quiet: got %0d want 0", seen); end
        do_run(2, 0);
        checks++; if (timed_out !== 0 || done_cnt !== 1) begin
            failures++; $display("FAIL rerun_done: got timeout %0d done %0d want 0 1", timed_out, done_cnt); end
        checks++; if (obs_q.size() !== IMG) begin
            failures++; $display("FAIL rerun_count: got %0d want %0d", obs_q.size(), IMG); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.img !== e.img || o.lbl !== e.lbl || o.scr !== e.scr) begin
                failures++; $display("FAIL rerun_result: got %0d/%0d/%h want %0d/%0d/%h",
                                     o.img, o.lbl, o.scr, e.img, e.lbl, e.scr); end
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_stall_signs_ties();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
